// File: rtl/myo_pkg.sv
// Shared myo link definitions.
// Used by the motor-board slave and the FPGA-side frame builder.
package myo_pkg;

  localparam logic [15:0] HEADER_DEFAULT = 16'h8000;
  localparam int FRAME_BITS = 128;
  localparam int WORD_BITS  = 16;

  // status word field positions
  localparam int ST_MARK   = 15;
  localparam int ST_TMO    = 14;
  localparam int ST_CNT_LO = 0;
  localparam int ST_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  function automatic logic [15:0] status_word(
    input logic       tmo,
    input logic [7:0] cnt
  );
    logic [15:0] w;
    w = '0;
    w[ST_MARK] = 1'b1;
    w[ST_TMO] = tmo;
    w[ST_CNT_LO +: ST_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/myo_spi_slave_sync_edge.sv
// Two-flop synchronizer plus a third flop for edge detect.
// Flops come out of reset at the line's idle level.
module spi_sync_edge #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // synchronize and keep one delayed copy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= IDLE_LVL;
      s2 <= IDLE_LVL;
      s3 <= IDLE_LVL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/myo_spi_slave.sv
// myo SPI slave: 16-bit words, MSB first, CPOL=0 CPHA=1.
// Receives the PWM reference, returns motor telemetry.
module myo_spi_slave
  import myo_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 5_000_000,
  parameter logic [15:0] HEADER         = HEADER_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sck,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  input  logic signed [31:0] position,
  input  logic [15:0]        velocity,
  input  logic [15:0]        current,
  input  logic [15:0]        displacement,
  input  logic [15:0]        sensor1,
  input  logic [15:0]        sensor2,
  output logic signed [15:0] pwm_ref,
  output logic               pwm_valid,
  output logic               frame_error,
  output logic               timed_out
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused;

  state_t state, state_nxt;
  logic snap, shifting, good, bad, frame_ok;

  logic [FRAME_BITS-1:0] tx;
  logic [FRAME_BITS-1:0] rx;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  full;
  logic                  ovf;
  logic [WD_W-1:0]       wd;
  logic [7:0]            frame_count;

  spi_sync_edge #(.IDLE_LVL(1'b0)) u_sck (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (sck),
    .level   (sck_lvl),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge #(.IDLE_LVL(1'b1)) u_ss (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (ss_n),
    .level   (ss_lvl),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  spi_sync_edge #(.IDLE_LVL(1'b0)) u_mosi (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (mosi),
    .level   (mosi_lvl),
    .rise    (mosi_rise),
    .fall    (mosi_fall)
  );

  assign unused = ^{sck_lvl, ss_lvl, mosi_rise, mosi_fall};

  assign frame_ok = full && !ovf && (bit_cnt == '0)
                 && (rx[FRAME_BITS-1 -: WORD_BITS] == HEADER);

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ss_fall) state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // per-state control strobes
  always_comb begin
    snap     = 1'b0;
    shifting = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
    unique case (state)
      IDLE:  snap = ss_fall;
      SHIFT: shifting = 1'b1;
      CHECK: begin
        good = frame_ok;
        bad  = !frame_ok;
      end
      default: ;
    endcase
  end

  // snapshot telemetry, shift tx out on rise, rx in on fall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      full    <= 1'b0;
      ovf     <= 1'b0;
      miso    <= 1'b0;
    end else if (snap) begin
      tx <= {status_word(timed_out, frame_count), position,
             velocity, current, displacement, sensor1, sensor2};
      rx      <= '0;
      bit_cnt <= '0;
      full    <= 1'b0;
      ovf     <= 1'b0;
      miso    <= 1'b0;
    end else if (shifting) begin
      if (sck_rise) begin
        miso <= tx[FRAME_BITS-1];
        tx   <= {tx[FRAME_BITS-2:0], 1'b0};
      end
      if (sck_fall) begin
        rx      <= {rx[FRAME_BITS-2:0], mosi_lvl};
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (full) ovf <= 1'b1;
        if (bit_cnt == CNT_LAST) full <= 1'b1;
      end
    end else begin
      miso <= 1'b0;
    end
  end

  // frame result, watchdog and latched reference
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_ref     <= '0;
      pwm_valid   <= 1'b0;
      frame_error <= 1'b0;
      timed_out   <= 1'b1;
      wd          <= '0;
      frame_count <= '0;
    end else begin
      pwm_valid   <= good;
      frame_error <= bad;
      if (good) begin
        pwm_ref     <= rx[FRAME_BITS-WORD_BITS-1 -: WORD_BITS];
        frame_count <= frame_count + 8'd1;
        wd          <= WD_LOAD;
        timed_out   <= 1'b0;
      end else if (wd > WD_W'(1)) begin
        wd <= wd - WD_W'(1);
      end else begin
        wd        <= '0;
        timed_out <= 1'b1;
        pwm_ref   <= '0;
      end
    end
  end

endmodule
